sha_core_arbiter: RTL
=====================

SHA_CORE_ARBITER -- requirements
Module: sha_core_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum number of cycles spent in LAUNCH plus WAIT_DONE before a job is abandoned.
REQ-002 The block SHALL have port tb_clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 2 bits: per-requester job request.
REQ-005 The block SHALL have port req_ready, output, 2 bits: per-requester job accepted this cycle.
REQ-006 The block SHALL have port req_state_flat, input, 512 bits: {state1, state0}; 256-bit initial hash state per requester.
REQ-007 The block SHALL have port req_block_flat, input, 1024 bits: {block1, block0}; 512-bit message block per requester.
REQ-008 The block SHALL have port core_init, output, 1 bit: first_state strobe to the sha_math_core.
REQ-009 The block SHALL have port core_state, output, 256 bits: initial_state to the core.
REQ-010 The block SHALL have port core_block, output, 512 bits: message_block to the core.
REQ-011 The block SHALL have port core_status, input, 1 bit: core ready.
REQ-012 The block SHALL have port core_valid, input, 1 bit: core hash valid.
REQ-013 The block SHALL have port core_hash, input, 256 bits: core digest.
REQ-014 The block SHALL have port rsp_valid, output, 2 bits: per-requester result pending.
REQ-015 The block SHALL have port rsp_ready, input, 2 bits: per-requester result consumed.
REQ-016 The block SHALL have port rsp_hash, output, 256 bits: result digest, shared by both requesters.
REQ-017 The block SHALL have port rsp_timeout, output, 1 bit: the current result is a timeout, not a digest.
REQ-018 The block SHALL have port busy, output, 1 bit: FSM not in IDLE.

Function
REQ-019 The FSM SHALL have exactly four states, IDLE, LAUNCH, WAIT_DONE and RESPOND, with one job in flight at a time.
REQ-020 In IDLE, on any req_valid, the block SHALL pick grant g round-robin: the requester other than last_grant wins a tie; a single requester wins outright.
REQ-021 In the IDLE accept cycle the block SHALL assert req_ready[g] only, latch state g and block g into core_state/core_block, and go to LAUNCH next cycle.
REQ-022 core_state and core_block SHALL be held stable from the accept cycle until RESPOND exits.
REQ-023 In LAUNCH the block SHALL wait for core_status=1, then assert core_init for exactly one cycle and move to WAIT_DONE.
REQ-024 In WAIT_DONE, on core_valid=1, the block SHALL register core_hash into rsp_hash, clear rsp_timeout, and enter RESPOND on the next cycle.
REQ-025 The 10-bit (clog2) timeout counter SHALL clear on accept and increment each cycle in LAUNCH/WAIT_DONE.
REQ-026 On reaching TIMEOUT_CYCLES the block SHALL set rsp_timeout=1 and rsp_hash=0 and enter RESPOND; a simultaneous core_valid takes priority over the timeout.
REQ-027 In RESPOND, rsp_valid[g] SHALL be held high until rsp_ready[g]=1 is sampled, then last_grant SHALL be set to g and the FSM SHALL return to IDLE.
REQ-028 A new accept SHALL be possible in the cycle after the return to IDLE.
REQ-029 rsp_valid SHALL be one-hot or zero, and req_ready SHALL be one-hot or zero, always.
REQ-030 core_valid seen outside WAIT_DONE SHALL be ignored, as SHALL rsp_ready on a non-granted lane.
REQ-031 Nominal latency SHALL be: accept T, core_init at T+1 if core_status was already high, rsp_valid one cycle after core_valid.
REQ-032 Requesters SHALL hold req_valid and data until req_ready; no behaviour is defined if they withdraw earlier.

Reset
REQ-033 While reset is high at a clock edge, the block SHALL set FSM=IDLE, last_grant=1 (requester 0 wins first tie), counter=0, and drive all outputs to 0.
REQ-034 A reset asserted mid-job SHALL drop the job: no rsp_valid, and no core_init until a new accept.

Structure
REQ-035 Package sha_sched_pkg SHALL hold the state enum, the width constants (STATE_W=256, BLOCK_W=512, NREQ=2) and the SHA-256 H0 constant used by other blocks.
REQ-036 A sub-module rr_arb2 SHALL provide the combinational two-way round-robin picker (req[1:0], last_grant -> grant one-hot); everything else stays in sha_core_arbiter.

Verification
REQ-037 The bench SHALL cover: req_valid=01, core_status=1, core_valid 64 cycles after core_init -> one core_init pulse, rsp_valid=01 with rsp_hash equal to the model digest, rsp_timeout=0.
REQ-038 The bench SHALL cover: req_valid=11 from reset -> grant 0 first, then grant 1; alternation continues for 4 jobs (0,1,0,1).
REQ-039 The bench SHALL cover: core_status held 0 for 20 cycles after accept -> core_init asserted on the first cycle core_status=1, never earlier.
REQ-040 The bench SHALL cover: TIMEOUT_CYCLES=8 and core_valid never asserted -> rsp_valid after 8 cycles with rsp_timeout=1 and rsp_hash=0.
REQ-041 The bench SHALL cover: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_hash stable throughout, and no req_ready during that time.
REQ-042 The bench SHALL cover: reset pulsed in WAIT_DONE -> all outputs 0 next cycle, no rsp_valid, and a late core_valid ignored.

Source files
------------

// File: rtl/sha_sched_pkg.sv
// Shared types and constants for the SHA job scheduler: widths, FSM states,
// and the SHA-256 initial hash value used by neighbouring blocks.
package sha_sched_pkg;

  localparam int STATE_W = 256;
  localparam int BLOCK_W = 512;
  localparam int NREQ    = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESPOND   = 2'd3
  } state_e;

  localparam logic [STATE_W-1:0] SHA256_H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [NREQ-1:0] lane_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sha_core_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, on a tie the
// requester that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sha_core_arbiter.sv
// Shares one sha_math_core between two requesters, one job in flight at a time,
// with a launch-to-done timeout that returns a timeout result instead of a digest.
//
//   state        | meaning
//   ST_IDLE      | no job; accept a request picked round-robin
//   ST_LAUNCH    | job latched; waiting for core ready to pulse core_init
//   ST_WAIT_DONE | core running; waiting for core_valid or timeout
//   ST_RESPOND   | result held for the granted requester until rsp_ready
module sha_core_arbiter
  import sha_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    tb_clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*STATE_W-1:0] req_state_flat,
  input  logic [NREQ*BLOCK_W-1:0] req_block_flat,
  output logic                    core_init,
  output logic [STATE_W-1:0]      core_state,
  output logic [BLOCK_W-1:0]      core_block,
  input  logic                    core_status,
  input  logic                    core_valid,
  input  logic [STATE_W-1:0]      core_hash,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [STATE_W-1:0]      rsp_hash,
  output logic                    rsp_timeout,
  output logic                    busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STATE_W-1:0]   core_state_q, core_state_d;
  logic [BLOCK_W-1:0]   core_block_q, core_block_d;
  logic [STATE_W-1:0]   rsp_hash_q, rsp_hash_d;
  logic                 rsp_tmo_q, rsp_tmo_d;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      req_ready_c;
  logic                 core_init_c;
  logic                 expire;

  rr_arb2 u_rr_arb2 (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign expire = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    core_state_d = core_state_q;
    core_block_d = core_block_q;
    rsp_hash_d   = rsp_hash_q;
    rsp_tmo_d    = rsp_tmo_q;
    req_ready_c  = '0;
    core_init_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready_c  = grant;
          gnt_d        = grant[1];
          core_state_d = grant[1] ? req_state_flat[2*STATE_W-1:STATE_W]
                                  : req_state_flat[STATE_W-1:0];
          core_block_d = grant[1] ? req_block_flat[2*BLOCK_W-1:BLOCK_W]
                                  : req_block_flat[BLOCK_W-1:0];
          cnt_d        = '0;
          state_d      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An expiring job is abandoned rather than started on its last cycle.
        if (expire) begin
          rsp_hash_d = '0;
          rsp_tmo_d  = 1'b1;
          state_d    = ST_RESPOND;
        end else if (core_status) begin
          core_init_c = 1'b1;
          state_d     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_valid) begin
          rsp_hash_d = core_hash;
          rsp_tmo_d  = 1'b0;
          state_d    = ST_RESPOND;
        end else if (expire) begin
          rsp_hash_d = '0;
          rsp_tmo_d  = 1'b1;
          state_d    = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tb_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      core_state_q <= '0;
      core_block_q <= '0;
      rsp_hash_q   <= '0;
      rsp_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      core_state_q <= core_state_d;
      core_block_q <= core_block_d;
      rsp_hash_q   <= rsp_hash_d;
      rsp_tmo_q    <= rsp_tmo_d;
    end
  end

  // Strobes are masked during reset so no requester sees a phantom accept.
  assign req_ready   = reset ? '0 : req_ready_c;
  assign core_init   = reset ? 1'b0 : core_init_c;
  assign core_state  = core_state_q;
  assign core_block  = core_block_q;
  assign rsp_valid   = (state_q == ST_RESPOND) ? lane_onehot(gnt_q) : '0;
  assign rsp_hash    = rsp_hash_q;
  assign rsp_timeout = rsp_tmo_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
